// File: rtl/sstv_vis_ctrl.sv
// SSTV receive sequencer: detects the end of the calibration header, then times
// and decodes the VIS frame (start, 7 data bits LSB first, even parity, stop).
module sstv_vis_ctrl #(
   parameter int TICKS_PER_BIT = 3000,
   parameter int FREQ_TOL      = 50,
   parameter int HDR_TIMEOUT   = 70000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [11:0] freq,
   input  logic        cal_active,
   input  logic        cal_ok,
   output logic        cal_reset,
   output logic [6:0]  vis_code,
   output logic        valid,
   input  logic        ack,
   output logic        parity_err,
   output logic        err,
   output logic        busy
);

   localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
   localparam int MW = $clog2(HDR_TIMEOUT + 1);

   localparam logic [TW-1:0] TICK_MID  = TW'(TICKS_PER_BIT / 2);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
   localparam logic [TW-1:0] TICK_ONE  = TW'(1);
   localparam logic [TW-1:0] TICK_ZERO = TW'(0);
   localparam logic [MW-1:0] TMO_LAST  = MW'(HDR_TIMEOUT - 1);
   localparam logic [MW-1:0] TMO_ONE   = MW'(1);
   localparam logic [MW-1:0] TMO_ZERO  = MW'(0);

   localparam logic signed [12:0] TONE_ONE  = 13'sd1100;
   localparam logic signed [12:0] TONE_SYNC = 13'sd1200;
   localparam logic signed [12:0] TONE_ZERO = 13'sd1300;
   localparam logic signed [12:0] TOL       = 13'(FREQ_TOL);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEADER = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
      PARITY = 3'd4,
      STOP   = 3'd5,
      DONE   = 3'd6,
      ERR    = 3'd7
   } state_t;

   // 13-bit signed difference so freq=0 and freq=12'hFFF cannot wrap into range
   function automatic logic in_tol(input logic [11:0] f, input logic signed [12:0] nom);
      logic signed [12:0] diff;
      logic signed [12:0] mag;
      diff = $signed({1'b0, f}) - nom;
      mag  = (diff < 13'sd0) ? -diff : diff;
      return (mag <= TOL);
   endfunction

   function automatic logic even_par(input logic [6:0] bits);
      return ^bits;
   endfunction

   state_t          state_r;
   logic [TW-1:0]   tick_r;
   logic [2:0]      bit_r;
   logic [MW-1:0]   tmo_r;
   logic            cal_reset_r;
   logic [6:0]      vis_code_r;
   logic            valid_r;
   logic            parity_err_r;
   logic            err_r;
   logic            busy_r;

   logic            one_s;
   logic            zero_s;
   logic            sync_s;
   logic            mid_s;
   logic            last_s;
   logic            tone_ok_s;

   assign one_s  = in_tol(freq, TONE_ONE);
   assign zero_s = in_tol(freq, TONE_ZERO);
   assign sync_s = in_tol(freq, TONE_SYNC);
   assign mid_s  = (tick_r == TICK_MID);
   assign last_s = (tick_r == TICK_LAST);

   // Which tones are legal in the bit currently being timed
   always_comb begin
      tone_ok_s = 1'b0;
      case (state_r)
         START, STOP:  tone_ok_s = sync_s;
         DATA, PARITY: tone_ok_s = one_s | zero_s;
         default:      tone_ok_s = 1'b0;
      endcase
   end

   // Sequencer state machine with all outputs registered
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r      <= IDLE;
         tick_r       <= TICK_ZERO;
         bit_r        <= 3'd0;
         tmo_r        <= TMO_ZERO;
         cal_reset_r  <= 1'b1;
         vis_code_r   <= 7'd0;
         valid_r      <= 1'b0;
         parity_err_r <= 1'b0;
         err_r        <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         err_r <= 1'b0;
         case (state_r)
            IDLE: begin
               cal_reset_r <= 1'b0;
               if (cal_active) begin
                  state_r <= LEADER;
                  tmo_r   <= TMO_ZERO;
                  busy_r  <= 1'b1;
               end
            end
            LEADER: begin
               if (cal_ok) begin
                  state_r      <= START;
                  tick_r       <= TICK_ZERO;
                  bit_r        <= 3'd0;
                  vis_code_r   <= 7'd0;
                  parity_err_r <= 1'b0;
                  cal_reset_r  <= 1'b1;
               end else if (!cal_active) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end else if (tmo_r == TMO_LAST) begin
                  state_r    <= ERR;
                  err_r      <= 1'b1;
                  vis_code_r <= 7'd0;
               end else begin
                  tmo_r <= tmo_r + TMO_ONE;
               end
            end
            START, DATA, PARITY, STOP: begin
               if (mid_s && !tone_ok_s) begin
                  state_r     <= ERR;
                  err_r       <= 1'b1;
                  vis_code_r  <= 7'd0;
                  cal_reset_r <= 1'b0;
               end else begin
                  // New bits enter at the top so the first bit ends up in bit 0
                  if (mid_s && state_r == DATA) begin
                     vis_code_r <= {one_s, vis_code_r[6:1]};
                  end
                  if (mid_s && state_r == PARITY) begin
                     parity_err_r <= one_s ^ even_par(vis_code_r);
                  end
                  if (last_s) begin
                     tick_r <= TICK_ZERO;
                     case (state_r)
                        START: begin
                           state_r <= DATA;
                           bit_r   <= 3'd0;
                        end
                        DATA: begin
                           if (bit_r == 3'd6) begin
                              state_r <= PARITY;
                           end else begin
                              bit_r <= bit_r + 3'd1;
                           end
                        end
                        PARITY: state_r <= STOP;
                        STOP: begin
                           state_r <= DONE;
                           valid_r <= 1'b1;
                        end
                        default: state_r <= IDLE;
                     endcase
                  end else begin
                     tick_r <= tick_r + TICK_ONE;
                  end
               end
            end
            DONE: begin
               if (ack) begin
                  state_r     <= IDLE;
                  valid_r     <= 1'b0;
                  busy_r      <= 1'b0;
                  cal_reset_r <= 1'b0;
               end
            end
            ERR: begin
               state_r     <= IDLE;
               busy_r      <= 1'b0;
               cal_reset_r <= 1'b0;
            end
            default: begin
               state_r     <= IDLE;
               valid_r     <= 1'b0;
               busy_r      <= 1'b0;
               cal_reset_r <= 1'b0;
            end
         endcase
      end
   end

   assign cal_reset  = cal_reset_r;
   assign vis_code   = vis_code_r;
   assign valid      = valid_r;
   assign parity_err = parity_err_r;
   assign err        = err_r;
   assign busy       = busy_r;

endmodule
